// File: rtl/nios2_system_sw_debounce_ctrl.sv
// nios2_system_sw_debounce_ctrl
// Avalon-MM slave presenting debounced slide switches at word 0, with
// optional edge capture and a level interrupt to the Nios II.
// Optional feature macro: SW_DEBOUNCE_EDGE_IRQ_EN enables irqmask,
// edgecapture, control and irq. Without it only the data register exists
// and irq is tied low.

// Per-bit stability counter: accepts a new level once it has differed from
// the debounced value across STABLE_TICKS consecutive prescaler ticks.
module nios2_system_sw_debounce_bit #(
    parameter int STABLE_TICKS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic sync_in,
    output logic deb
);
    localparam int CNT_W = $clog2(STABLE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic [CNT_W-1:0] cnt;

    // Any cycle of agreement restarts qualification, so glitches never land.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            deb <= 1'b0;
        end else if (sync_in == deb) begin
            cnt <= '0;
        end else if (tick) begin
            if (cnt == CNT_LAST) begin
                deb <= sync_in;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module nios2_system_sw_debounce_ctrl #(
    parameter int WIDTH        = 10,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [WIDTH-1:0] sync1, sync2, deb;
    logic [PRE_W-1:0] pre;
    logic             tick;
    logic [31:0]      rd_mux;
    logic             unused_ok;

    // Two-flop synchroniser for the asynchronous switch levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    // Shared prescaler; tick marks the last count of each period.
    always_ff @(posedge clk) begin
        if (reset)     pre <= '0;
        else if (tick) pre <= '0;
        else           pre <= pre + 1'b1;
    end

    assign tick = (pre == PRE_LAST);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        nios2_system_sw_debounce_bit #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_bit (
            .clk    (clk),
            .reset  (reset),
            .tick   (tick),
            .sync_in(sync2[i]),
            .deb    (deb[i])
        );
    end

`ifdef SW_DEBOUNCE_EDGE_IRQ_EN
    logic [WIDTH-1:0] deb_q, irqmask, edgecapture, edge_set, edge_clr;
    logic             both_edges;
    logic             wr_en;

    assign wr_en     = chipselect & write;
    assign unused_ok = &{1'b0, writedata};

    // One-cycle delayed copy of deb for edge detection.
    always_ff @(posedge clk) begin
        if (reset) deb_q <= '0;
        else       deb_q <= deb;
    end

    // Edge set/clear terms; a set in the same cycle as a clear wins.
    always_comb begin
        edge_set = both_edges ? (deb ^ deb_q) : (deb & ~deb_q);
        edge_clr = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : '0;
    end

    // Software-visible mask, capture and control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask     <= '0;
            edgecapture <= '0;
            both_edges  <= 1'b0;
        end else begin
            edgecapture <= (edgecapture & ~edge_clr) | edge_set;
            if (wr_en && address == 2'd1) irqmask    <= writedata[WIDTH-1:0];
            if (wr_en && address == 2'd3) both_edges <= writedata[0];
        end
    end

    // Registered level interrupt from masked captured edges.
    always_ff @(posedge clk) begin
        if (reset) irq <= 1'b0;
        else       irq <= |(edgecapture & irqmask);
    end

    // Read mux; registered below.
    always_comb begin
        case (address)
            2'd1:    rd_mux = 32'(irqmask);
            2'd2:    rd_mux = 32'(edgecapture);
            2'd3:    rd_mux = {31'd0, both_edges};
            default: rd_mux = 32'(deb);
        endcase
    end
`else
    assign unused_ok = &{1'b0, writedata, chipselect, write};
    assign irq       = 1'b0;

    // Read mux: only the data register exists.
    always_comb begin
        rd_mux = (address == 2'd0) ? 32'(deb) : 32'd0;
    end
`endif

    // Read data registered every cycle, independent of chipselect.
    always_ff @(posedge clk) begin
        if (reset) readdata <= '0;
        else       readdata <= rd_mux;
    end
endmodule

// File: tb/tb_nios2_system_sw_debounce_ctrl.sv
// Self-checking bench for nios2_system_sw_debounce_ctrl with a cycle-level
// behavioural model driven from the register-map rules.
`timescale 1ns/1ps
module tb_nios2_system_sw_debounce_ctrl;
    localparam int WIDTH = 10, TICK_DIV = 4, STABLE_TICKS = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] in_port = '0;
    logic [1:0]       address = '0;
    logic             chipselect = 1'b0, write = 1'b0;
    logic [31:0]      writedata = '0;
    logic [31:0]      readdata;
    logic             irq;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    nios2_system_sw_debounce_ctrl #(
        .WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .STABLE_TICKS(STABLE_TICKS)
    ) dut (
        .clk(clk), .reset(reset), .in_port(in_port), .address(address),
        .chipselect(chipselect), .write(write), .writedata(writedata),
        .readdata(readdata), .irq(irq)
    );

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] m_s1, m_s2, m_deb, m_deb_q, m_mask, m_ec;
    logic             m_ctrl, m_irq;
    logic [31:0]      m_rd;
    int               m_cyc;
    int               m_len[WIDTH];   // consecutive cycles sync2 != deb

    // Number of prescaler ticks falling in cycles a..b (tick when cyc%D==D-1).
    function automatic int ticks_in(int a, int b);
        return (b + 1) / TICK_DIV - a / TICK_DIV;
    endfunction

    always @(posedge clk) begin
        logic [WIDTH-1:0] n_deb, set, clr;
        logic [31:0]      n_rd;
        logic             n_irq;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_deb_q = '0;
            m_mask = '0; m_ec = '0; m_ctrl = 1'b0; m_irq = 1'b0; m_rd = '0;
            m_cyc = 0;
            foreach (m_len[i]) m_len[i] = 0;
        end else begin
            n_rd = 32'd0;
`ifdef SW_DEBOUNCE_EDGE_IRQ_EN
            case (address)
                2'd0: n_rd = 32'(m_deb);
                2'd1: n_rd = 32'(m_mask);
                2'd2: n_rd = 32'(m_ec);
                default: n_rd = {31'd0, m_ctrl};
            endcase
            n_irq = |(m_ec & m_mask);
`else
            if (address == 2'd0) n_rd = 32'(m_deb);
            n_irq = 1'b0;
`endif
            n_deb = m_deb;
            for (int i = 0; i < WIDTH; i++) begin
                if (m_s2[i] != m_deb[i]) begin
                    m_len[i]++;
                    if (m_cyc % TICK_DIV == TICK_DIV - 1 &&
                        ticks_in(m_cyc - m_len[i] + 1, m_cyc) >= STABLE_TICKS) begin
                        n_deb[i] = m_s2[i];
                        m_len[i] = 0;
                    end
                end else begin
                    m_len[i] = 0;
                end
            end
            set = m_ctrl ? (m_deb ^ m_deb_q) : (m_deb & ~m_deb_q);
            clr = (chipselect && write && address == 2'd2) ? writedata[WIDTH-1:0] : '0;
            m_ec = (m_ec & ~clr) | set;
            if (chipselect && write && address == 2'd1) m_mask = writedata[WIDTH-1:0];
            if (chipselect && write && address == 2'd3) m_ctrl = writedata[0];
            m_deb_q = m_deb;
            m_deb   = n_deb;
            m_s2    = m_s1;
            m_s1    = in_port;
            m_rd    = n_rd;
            m_irq   = n_irq;
            m_cyc++;
        end
    end

    // ---------------- stimulus helpers (start/end at negedge) ----------------
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int first;
        reset = 1'b1; in_port = '1; address = 2'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (readdata !== 32'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: readdata=%h irq=%b, expected 0/0", readdata, irq);
        end
        reset = 1'b0;
        first = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            checks++;
            if (readdata !== m_rd) begin
                errors++;
                $display("FAIL reset_qual_model c=%0d: readdata=%h expected %h", c, readdata, m_rd);
            end
            checks++;
            if (irq !== 1'b0) begin
                errors++;
                $display("FAIL reset_irq c=%0d: irq=%b expected 0", c, irq);
            end
            if (first < 0) begin
                if (readdata === 32'h3FF) first = c;
                else if (readdata !== 32'd0) begin
                    errors++;
                    $display("FAIL reset_partial c=%0d: readdata=%h expected 0 or 3ff", c, readdata);
                end
            end
        end
        checks++;
        if (first < 0 || first > 15) begin
            errors++;
            $display("FAIL reset_latency: first cycle=%0d expected 1..15", first);
        end
    endtask

    task automatic test_glitch();
        in_port = '0;
        repeat (20) @(negedge clk);
        wr(2'd2, 32'h3FF);
        address = 2'd0;
        @(negedge clk);
        in_port = 10'h001;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (c == 4) in_port = '0;
            checks++;
            if (readdata !== 32'd0 || readdata !== m_rd) begin
                errors++;
                $display("FAIL glitch_data c=%0d: readdata=%h expected 0 (model %h)", c, readdata, m_rd);
            end
        end
`ifdef SW_DEBOUNCE_EDGE_IRQ_EN
        address = 2'd2;
        @(negedge clk);
        checks++;
        if (readdata !== 32'd0) begin
            errors++;
            $display("FAIL glitch_edgecapture: readdata=%h expected 0", readdata);
        end
`endif
    endtask

`ifdef SW_DEBOUNCE_EDGE_IRQ_EN
    task automatic test_irq();
        int t_ec, t_irq;
        wr(2'd1, 32'h004);
        address = 2'd2; in_port = 10'h004;
        t_ec = -1; t_irq = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            checks++;
            if (readdata !== m_rd || irq !== m_irq) begin
                errors++;
                $display("FAIL irq_model c=%0d: readdata=%h irq=%b expected %h/%b", c, readdata, irq, m_rd, m_irq);
            end
            if (t_ec < 0 && readdata[2] === 1'b1) t_ec = c;
            if (t_irq < 0 && irq === 1'b1) t_irq = c;
        end
        checks++;
        if (readdata !== 32'h004 || irq !== 1'b1 || t_ec < 0 || t_irq != t_ec) begin
            errors++;
            $display("FAIL irq_assert: ec=%h irq=%b t_ec=%0d t_irq=%0d expected 004/1 equal times", readdata, irq, t_ec, t_irq);
        end
        wr(2'd2, 32'h004);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_clear_edge: irq=%b expected 1 at write edge", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear: irq=%b expected 0 one cycle after write", irq);
        end
    endtask

    task automatic run_bit5_fall(input logic both, input logic [31:0] expect_ec);
        wr(2'd3, {31'd0, both});
        address = 2'd3;
        @(negedge clk);
        checks++;
        if (readdata !== {31'd0, both}) begin
            errors++;
            $display("FAIL control_read: readdata=%h expected %h", readdata, {31'd0, both});
        end
        in_port = 10'h024;
        repeat (20) @(negedge clk);
        wr(2'd2, 32'h3FF);
        in_port = 10'h004; address = 2'd2;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (readdata !== m_rd) begin
                errors++;
                $display("FAIL fall_model c=%0d: readdata=%h expected %h", c, readdata, m_rd);
            end
        end
        checks++;
        if (readdata !== expect_ec) begin
            errors++;
            $display("FAIL fall_edgecapture both=%b: readdata=%h expected %h", both, readdata, expect_ec);
        end
    endtask

    task automatic test_both_edges();
        run_bit5_fall(1'b1, 32'h020);
        run_bit5_fall(1'b0, 32'h000);
    endtask

    task automatic test_set_wins();
        bit hit;
        wr(2'd2, 32'h3FF);
        in_port = 10'h00C;
        hit = 0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge clk);
            if (m_deb[3] && !m_deb_q[3]) hit = 1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL set_wins_timeout: bit3 never rose, deb=%h", m_deb);
        end else begin
            wr(2'd2, 32'h008);
            address = 2'd2;
            @(negedge clk);
            checks++;
            if (readdata[3] !== 1'b1 || readdata !== m_rd) begin
                errors++;
                $display("FAIL set_wins: edgecapture=%h expected bit3 set (model %h)", readdata, m_rd);
            end
        end
    endtask
`else
    task automatic test_disabled();
        wr(2'd1, 32'h3FF);
        wr(2'd2, 32'h3FF);
        wr(2'd3, 32'h3FF);
        for (int a = 1; a < 4; a++) begin
            address = 2'(a);
            @(negedge clk);
            checks++;
            if (readdata !== 32'd0) begin
                errors++;
                $display("FAIL disabled_read addr=%0d: readdata=%h expected 0", a, readdata);
            end
        end
        address = 2'd0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (c % 20 == 0) in_port = WIDTH'($urandom);
            checks++;
            if (irq !== 1'b0 || readdata !== m_rd) begin
                errors++;
                $display("FAIL disabled_activity c=%0d: irq=%b readdata=%h expected 0/%h", c, irq, readdata, m_rd);
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            checks++;
            if (readdata !== m_rd || irq !== m_irq) begin
                errors++;
                $display("FAIL random c=%0d: readdata=%h irq=%b expected %h/%b", c, readdata, irq, m_rd, m_irq);
            end
            chipselect = 1'b0; write = 1'b0; reset = 1'b0;
            if ($urandom_range(0, 15) == 0) in_port = in_port ^ WIDTH'($urandom);
            address = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                chipselect = 1'b1; write = 1'b1; writedata = $urandom;
            end else begin
                chipselect = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 299) == 0) reset = 1'b1;
        end
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0; reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_glitch();
`ifdef SW_DEBOUNCE_EDGE_IRQ_EN
        test_irq();
        test_both_edges();
        test_set_wins();
`else
        test_disabled();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
